cgra_ctrl: RTL and testbench

- Control stage directly upstream of the CGRA array.
- Accepts a 32-bit context stream from the cluster side and packs each pair of beats into one 64-bit configuration word.
- Writes each word into the tiles through the DMA_Read_En / DMA_Data_In / DMA_Addr_In interface.
- After the last word it raises Exec_En, waits until every tile reports End_Exec, then signals completion to the host.

---
 rtl/cgra_ctrl_pkg.sv | 21 ++
 rtl/cgra_ctrl_cfg_packer.sv | 46 ++++
 rtl/cgra_ctrl.sv | 131 +++++++++++++
 tb/tb_cgra_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cgra_ctrl_pkg : shared state encoding, default widths and word type
// Rev 1.0
// ============================================================================
package cgra_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } ctrl_state_e;

  localparam int CFG_ADDR_W_DEF = 23;
  localparam int LEN_W_DEF      = 16;

  typedef logic [63:0] cfg_word_t;

endpackage
`default_nettype wire

// File: rtl/cgra_ctrl_cfg_packer.sv
`default_nettype none
// ============================================================================
// cfg_packer : packs pairs of 32-bit beats into one 64-bit word, one-cycle strobe
// Rev 1.0
// ============================================================================
module cfg_packer
  import cgra_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        beat_fire,
  input  logic [31:0] beat_data,
  output logic        half,
  output logic        strobe,
  output cfg_word_t   word
);

  logic [31:0] low;

  always_ff @(posedge clk) begin
    if (rst) begin
      half   <= 1'b0;
      low    <= '0;
      strobe <= 1'b0;
      word   <= '0;
    end else begin
      strobe <= 1'b0;
      if (clear) begin
        half <= 1'b0;
      end else if (beat_fire) begin
        if (!half) begin
          low  <= beat_data;
          half <= 1'b1;
        end else begin
          // word holds its value between strobes
          word   <= {beat_data, low};
          strobe <= 1'b1;
          half   <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cgra_ctrl.sv
`default_nettype none
// ============================================================================
// cgra_ctrl : loads a packed context into the CGRA tiles, runs it, reports done
// Optional watchdog on EXEC enabled by macro CGRA_CTRL_TIMEOUT_EN. Rev 1.0
// ============================================================================
module cgra_ctrl
  import cgra_ctrl_pkg::*;
#(
  parameter int NB_ROWS    = 4,
  parameter int NB_COLS    = 4,
  parameter int CFG_ADDR_W = CFG_ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start_I,
  input  logic [CFG_ADDR_W-1:0]     Base_Addr_I,
  input  logic [LEN_W-1:0]          Ctx_Len_I,
  input  logic                      Cfg_Valid_I,
  output logic                      Cfg_Ready_O,
  input  logic [31:0]               Cfg_Data_I,
  input  logic                      Cfg_Last_I,
  output logic                      DMA_Read_En,
  output logic [63:0]               DMA_Data_In,
  output logic [CFG_ADDR_W-1:0]     DMA_Addr_In,
  output logic                      Exec_En,
  input  logic [NB_ROWS*NB_COLS-1:0] End_Exec_I,
  output logic                      Busy_O,
  output logic                      Done_O,
  output logic                      Err_O
);

  ctrl_state_e            state_q, state_d;
  logic [CFG_ADDR_W-1:0]  base_q;
  logic [CFG_ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       word_idx;
  logic                   err_q;
  logic                   half;
  logic                   strobe;
  cfg_word_t              word;
  logic                   to_hit;

  logic start_ok, beat_fire, final_beat, all_words, early_last, missing_last, all_end;

  assign start_ok     = (state_q == IDLE) && Start_I;
  assign all_words    = (word_idx == len_q);
  assign Cfg_Ready_O  = (state_q == LOAD) && !all_words;
  assign beat_fire    = Cfg_Valid_I && Cfg_Ready_O;
  assign final_beat   = half && (word_idx == len_q - LEN_W'(1));
  assign early_last   = beat_fire && Cfg_Last_I && !final_beat;
  assign missing_last = beat_fire && final_beat && !Cfg_Last_I;
  assign all_end      = &End_Exec_I;

  cfg_packer u_packer (
    .clk       (Clk),
    .rst       (Reset),
    .clear     (start_ok),
    .beat_fire (beat_fire),
    .beat_data (Cfg_Data_I),
    .half      (half),
    .strobe    (strobe),
    .word      (word)
  );

`ifdef CGRA_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || state_q != EXEC) to_cnt <= '0;
    else                          to_cnt <= to_cnt + TIMEOUT_W'(1);
  end

  // fires in the EXEC cycle whose increment brings the counter to all-ones
  assign to_hit = (state_q == EXEC) && (to_cnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start_I) state_d = (Ctx_Len_I == '0) ? EXEC : LOAD;
      // EXEC entry waits for the final strobe so the two never overlap
      LOAD: if (early_last)              state_d = IDLE;
            else if (strobe && all_words) state_d = EXEC;
      EXEC: if (all_end || to_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      base_q   <= '0;
      len_q    <= '0;
      word_idx <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q   <= Base_Addr_I;
        len_q    <= Ctx_Len_I;
        word_idx <= '0;
        err_q    <= 1'b0;
      end
      if (beat_fire && half) begin
        addr_q   <= base_q + CFG_ADDR_W'(word_idx);
        word_idx <= word_idx + LEN_W'(1);
      end
      if (early_last || missing_last) err_q <= 1'b1;
      if (to_hit && !all_end)          err_q <= 1'b1;
    end
  end

  assign DMA_Read_En = strobe;
  assign DMA_Data_In = word;
  assign DMA_Addr_In = addr_q;
  assign Exec_En     = (state_q == EXEC);
  assign Busy_O      = (state_q != IDLE);
  assign Done_O      = (state_q == DONE);
  assign Err_O       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cgra_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cgra_ctrl : directed bench with a write-queue model of expected tile writes
// Rev 1.0
// ============================================================================
module tb_cgra_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start_I = 1'b0;
  logic [22:0] Base_Addr_I = '0;
  logic [15:0] Ctx_Len_I = '0;
  logic        Cfg_Valid_I = 1'b0;
  logic        Cfg_Ready_O;
  logic [31:0] Cfg_Data_I = '0;
  logic        Cfg_Last_I = 1'b0;
  logic        DMA_Read_En;
  logic [63:0] DMA_Data_In;
  logic [22:0] DMA_Addr_In;
  logic        Exec_En;
  logic [15:0] End_Exec_I = '0;
  logic        Busy_O, Done_O, Err_O;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [22:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 Clk = ~Clk;

  cgra_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start_I(Start_I), .Base_Addr_I(Base_Addr_I),
    .Ctx_Len_I(Ctx_Len_I), .Cfg_Valid_I(Cfg_Valid_I), .Cfg_Ready_O(Cfg_Ready_O),
    .Cfg_Data_I(Cfg_Data_I), .Cfg_Last_I(Cfg_Last_I), .DMA_Read_En(DMA_Read_En),
    .DMA_Data_In(DMA_Data_In), .DMA_Addr_In(DMA_Addr_In), .Exec_En(Exec_En),
    .End_Exec_I(End_Exec_I), .Busy_O(Busy_O), .Done_O(Done_O), .Err_O(Err_O)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start(input logic [22:0] base, input logic [15:0] len);
    Start_I = 1'b1; Base_Addr_I = base; Ctx_Len_I = len;
    tick();
    Start_I = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    Cfg_Valid_I = 1'b1; Cfg_Data_I = d; Cfg_Last_I = last;
    while (!Cfg_Ready_O && n < 20) begin tick(); n++; end
    if (!Cfg_Ready_O) chk("beat_ready_timeout", 64'(Cfg_Ready_O), 64'd1);
    tick();
    Cfg_Valid_I = 1'b0; Cfg_Last_I = 1'b0;
  endtask

  // Model: word i of a context lives at (base+i) mod 2^23 and is {odd beat, even beat}
  task automatic model_words(input logic [22:0] base, input logic [31:0] beats[], input int nwords);
    for (int i = 0; i < nwords; i++) begin
      wr_t w;
      w.addr = base + 23'(i);
      w.data = {beats[2*i+1], beats[2*i]};
      exp_q.push_back(w);
    end
  endtask

  // Every strobe must match the next modelled write; strobe and Exec_En never overlap
  always @(negedge Clk) begin
    if (!Reset) begin
      if (DMA_Read_En) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("strobe_addr", 64'(DMA_Addr_In), 64'(e.addr));
          chk("strobe_data", DMA_Data_In, e.data);
        end
        chk("strobe_exec_overlap", 64'(Exec_En), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b[];

    // Reset state
    tick(); tick();
    chk("rst_outputs", {57'd0, DMA_Read_En, Exec_En, Busy_O, Done_O, Err_O, Cfg_Ready_O, 1'b0}, 64'd0);
    chk("rst_data", DMA_Data_In, 64'd0);
    chk("rst_addr", 64'(DMA_Addr_In), 64'd0);
    Reset = 1'b0;
    tick();

    // Test 1: three words back-to-back
    b = new[6];
    b = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    model_words(23'h000100, b, 3);
    start(23'h000100, 16'd3);
    chk("t1_busy", 64'(Busy_O), 64'd1);
    for (int i = 0; i < 6; i++) send_beat(b[i], i == 5);
    chk("t1_last_strobe", 64'(DMA_Read_En), 64'd1);
    chk("t1_last_addr", 64'(DMA_Addr_In), 64'h102);
    chk("t1_last_data", DMA_Data_In, 64'h00000066_00000055);
    chk("t1_exec_during_strobe", 64'(Exec_En), 64'd0);
    tick();
    chk("t1_exec_rise", 64'(Exec_En), 64'd1);
    chk("t1_err", 64'(Err_O), 64'd0);

    // Test 2: completion only once all tiles report
    End_Exec_I = 16'hFFFE;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_exec_hold", {62'd0, Exec_En, Done_O}, 64'b10);
    end
    End_Exec_I = 16'hFFFF;
    tick();
    chk("t2_done", {61'd0, Done_O, Exec_En, Busy_O}, 64'b101);
    End_Exec_I = 16'h0000;
    tick();
    chk("t2_after_done", {62'd0, Done_O, Busy_O}, 64'b00);

    // Test 3: premature Last on the odd beat of word 0
    b = new[2];
    b = '{32'hA1, 32'hA2};
    model_words(23'h000200, b, 1);
    start(23'h000200, 16'd2);
    send_beat(b[0], 1'b0);
    send_beat(b[1], 1'b1);
    chk("t3_err", 64'(Err_O), 64'd1);
    chk("t3_idle", 64'(Busy_O), 64'd0);
    End_Exec_I = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_quiet", {61'd0, Exec_En, Done_O, Err_O}, 64'b001);
    end
    End_Exec_I = 16'h0000;

    // Test 4: address wrap; the new Start clears Err_O
    b = new[4];
    b = '{32'h1, 32'h2, 32'h3, 32'h4};
    model_words(23'h7FFFFF, b, 2);
    start(23'h7FFFFF, 16'd2);
    chk("t4_err_cleared", 64'(Err_O), 64'd0);
    for (int i = 0; i < 4; i++) send_beat(b[i], i == 3);
    chk("t4_wrap_addr", 64'(DMA_Addr_In), 64'h0);
    tick();
    chk("t4_exec", 64'(Exec_En), 64'd1);
    End_Exec_I = 16'hFFFF;
    tick();
    chk("t4_done", 64'(Done_O), 64'd1);
    End_Exec_I = 16'h0000;
    tick();

    // Missing Last on the final beat: error flagged, still executes
    b = new[2];
    b = '{32'hC1, 32'hC2};
    model_words(23'h000010, b, 1);
    start(23'h000010, 16'd1);
    send_beat(b[0], 1'b0);
    send_beat(b[1], 1'b0);
    chk("ml_err", 64'(Err_O), 64'd1);
    tick();
    chk("ml_exec", 64'(Exec_En), 64'd1);
    End_Exec_I = 16'hFFFF;
    tick();
    chk("ml_done_err", {62'd0, Done_O, Err_O}, 64'b11);
    End_Exec_I = 16'h0000;
    tick();

    // Test 5: reset on the odd-beat handshake drops the word
    start(23'h000300, 16'd2);
    send_beat(32'hB1, 1'b0);
    Cfg_Valid_I = 1'b1; Cfg_Data_I = 32'hB2; Reset = 1'b1;
    tick();
    chk("t5_rst_outputs", {58'd0, DMA_Read_En, Exec_En, Busy_O, Done_O, Err_O, Cfg_Ready_O}, 64'd0);
    chk("t5_rst_data", DMA_Data_In, 64'd0);
    chk("t5_rst_addr", 64'(DMA_Addr_In), 64'd0);
    Reset = 1'b0; Cfg_Valid_I = 1'b0;
    tick();

    // Zero-length context goes straight to EXEC; Start in EXEC is ignored
    start(23'h000400, 16'd0);
    chk("t5_len0_exec", 64'(Exec_En), 64'd1);
    start(23'h000500, 16'd1);
    chk("t5_start_in_exec", {62'd0, Exec_En, Busy_O}, 64'b11);
    for (int i = 0; i < 100; i++) tick();
    chk("t6_no_timeout", 64'(Exec_En), 64'd1);
    End_Exec_I = 16'hFFFF;
    tick();
    chk("t5_done", 64'(Done_O), 64'd1);
    // Start coinciding with DONE->IDLE is not honoured
    Start_I = 1'b1; Ctx_Len_I = 16'd0;
    tick();
    Start_I = 1'b0;
    chk("t5_done_to_idle", 64'(Busy_O), 64'd0);
    tick();
    chk("t5_start_at_done_ignored", 64'(Busy_O), 64'd0);
    End_Exec_I = 16'h0000;
    tick();

    chk("leftover_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
